writeback_stage: RTL and testbench

- Final pipeline stage and the write-side driver of the register file.
- Accepts completed instructions from MEM over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Selects the result source and formats load data with byte/half extraction and sign or zero extension.
- Drives the register file write port (writeEnable/writeAddr/writeDate) and exposes the committed write for forwarding.

---
 rtl/writeback_stage_pkg.sv | 27 ++
 rtl/writeback_stage_load_formatter.sv | 42 ++++
 rtl/writeback_stage.sv | 102 ++++++++++
 tb/tb_writeback_stage.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared widths, result-source and load-type encodings, and the FIFO entry layout
// used by the writeback stage.
package writeback_stage_pkg;

  localparam int DataSize    = 32;
  localparam int RegAddrSize = 5;
  localparam int WbFifoDepth = 2;

  localparam logic [DataSize-1:0] DataBusReset = '0;

  localparam logic [1:0] WbSelAlu  = 2'b00;
  localparam logic [1:0] WbSelLoad = 2'b01;
  localparam logic [1:0] WbSelPc   = 2'b10;

  localparam logic [2:0] LoadB  = 3'b000;
  localparam logic [2:0] LoadH  = 3'b001;
  localparam logic [2:0] LoadW  = 3'b010;
  localparam logic [2:0] LoadBU = 3'b100;
  localparam logic [2:0] LoadHU = 3'b101;

  typedef struct packed {
    logic [RegAddrSize-1:0] rd;
    logic                   we;
    logic [DataSize-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_stage_load_formatter.sv
// Combinational load-data formatter: picks the byte or half addressed by addrLow
// out of the aligned word and sign- or zero-extends it.
module load_formatter
  import writeback_stage_pkg::*;
(
  input  logic [2:0]          loadType,
  input  logic [1:0]          addrLow,
  input  logic [DataSize-1:0] loadWord,
  output logic [DataSize-1:0] loadData,
  output logic                loadErr
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = loadWord[7:0];
    case (addrLow)
      2'd0: byte_val = loadWord[7:0];
      2'd1: byte_val = loadWord[15:8];
      2'd2: byte_val = loadWord[23:16];
      2'd3: byte_val = loadWord[31:24];
      default: byte_val = loadWord[7:0];
    endcase
    half_val = addrLow[1] ? loadWord[31:16] : loadWord[15:0];
  end

  // Unsupported funct3 values still pass the raw word through.
  always_comb begin
    loadData = loadWord;
    loadErr  = 1'b0;
    case (loadType)
      LoadB:   loadData = {{24{byte_val[7]}}, byte_val};
      LoadBU:  loadData = {24'd0, byte_val};
      LoadH:   loadData = {{16{half_val[15]}}, half_val};
      LoadHU:  loadData = {16'd0, half_val};
      LoadW:   loadData = loadWord;
      default: loadErr  = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: buffers completed instructions in a 2-entry FIFO and
// commits one per cycle to the register file write port.
module writeback_stage
  import writeback_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetIn,
  input  logic                   memValid,
  output logic                   memReady,
  input  logic                   memRegWrite,
  input  logic [RegAddrSize-1:0] memRdAddr,
  input  logic [1:0]             memWbSel,
  input  logic [2:0]             memLoadType,
  input  logic [1:0]             memAddrLow,
  input  logic [DataSize-1:0]    memAluResult,
  input  logic [DataSize-1:0]    memLoadWord,
  input  logic [DataSize-1:0]    memPcPlus4,
  input  logic                   stallIn,
  output logic                   writeEnable,
  output logic [RegAddrSize-1:0] writeAddr,
  output logic [DataSize-1:0]    writeDate,
  output logic                   fwdValid,
  output logic [RegAddrSize-1:0] fwdAddr,
  output logic [DataSize-1:0]    fwdData,
  output logic [31:0]            retireCount,
  output logic                   loadErr
);

  wb_entry_t           fifo_q [WbFifoDepth];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          count;
  logic                push;
  logic                pop;
  logic [DataSize-1:0] fmt_data;
  logic                fmt_err;
  wb_entry_t           push_entry;
  wb_entry_t           head;

  load_formatter u_load_formatter (
    .loadType (memLoadType),
    .addrLow  (memAddrLow),
    .loadWord (memLoadWord),
    .loadData (fmt_data),
    .loadErr  (fmt_err)
  );

  // Ready depends only on the registered count, so a same-cycle pop never frees a slot.
  assign memReady = !resetIn && (count < 2'd2);
  assign push     = memValid && memReady;
  assign pop      = (count != 2'd0) && !stallIn;
  assign head     = fifo_q[rd_ptr];

  always_comb begin
    push_entry.rd = memRdAddr;
    push_entry.we = memRegWrite && (memRdAddr != '0);
    case (memWbSel)
      WbSelLoad: push_entry.data = fmt_data;
      WbSelPc:   push_entry.data = memPcPlus4;
      default:   push_entry.data = memAluResult;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetIn) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      writeEnable <= 1'b0;
      writeAddr   <= '0;
      writeDate   <= DataBusReset;
      retireCount <= 32'd0;
      loadErr     <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= push_entry;
        wr_ptr         <= ~wr_ptr;
        if ((memWbSel == WbSelLoad) && fmt_err)
          loadErr <= 1'b1;
      end
      if (pop) begin
        rd_ptr      <= ~rd_ptr;
        writeEnable <= head.we;
        writeAddr   <= head.rd;
        writeDate   <= head.data;
        retireCount <= retireCount + 32'd1;
      end else begin
        writeEnable <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign fwdValid = writeEnable;
  assign fwdAddr  = writeAddr;
  assign fwdData  = writeDate;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: a queue-based model checked every cycle,
// plus directed vectors with hand-computed literal results.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        resetIn = 1'b1;
  logic        memValid = 1'b0;
  logic        memReady;
  logic        memRegWrite = 1'b0;
  logic [4:0]  memRdAddr = '0;
  logic [1:0]  memWbSel = '0;
  logic [2:0]  memLoadType = '0;
  logic [1:0]  memAddrLow = '0;
  logic [31:0] memAluResult = '0;
  logic [31:0] memLoadWord = '0;
  logic [31:0] memPcPlus4 = '0;
  logic        stallIn = 1'b0;
  logic        writeEnable;
  logic [4:0]  writeAddr;
  logic [31:0] writeDate;
  logic        fwdValid;
  logic [4:0]  fwdAddr;
  logic [31:0] fwdData;
  logic [31:0] retireCount;
  logic        loadErr;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk          (clk),
    .resetIn      (resetIn),
    .memValid     (memValid),
    .memReady     (memReady),
    .memRegWrite  (memRegWrite),
    .memRdAddr    (memRdAddr),
    .memWbSel     (memWbSel),
    .memLoadType  (memLoadType),
    .memAddrLow   (memAddrLow),
    .memAluResult (memAluResult),
    .memLoadWord  (memLoadWord),
    .memPcPlus4   (memPcPlus4),
    .stallIn      (stallIn),
    .writeEnable  (writeEnable),
    .writeAddr    (writeAddr),
    .writeDate    (writeDate),
    .fwdValid     (fwdValid),
    .fwdAddr      (fwdAddr),
    .fwdData      (fwdData),
    .retireCount  (retireCount),
    .loadErr      (loadErr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  ent_t        mq[$];
  wr_t         wlog[$];
  bit          model_on = 0;
  logic        m_we = 0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic [31:0] m_ret = '0;
  logic        m_lerr = 0;
  ent_t        m_new;
  ent_t        m_head;
  bit          m_push;
  bit          m_pop;

  function automatic logic [31:0] model_data(input logic [1:0] sel, input logic [2:0] lt,
                                             input logic [1:0] al, input logic [31:0] alu,
                                             input logic [31:0] word, input logic [31:0] pc);
    logic [7:0]  b;
    logic [15:0] h;
    if (sel == 2'b10) return pc;
    if (sel != 2'b01) return alu;
    b = word[8*al +: 8];
    h = word[16*al[1] +: 16];
    case (lt)
      3'b000:  return 32'($signed(b));
      3'b100:  return {24'd0, b};
      3'b001:  return 32'($signed(h));
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  always @(posedge clk) begin
    if (resetIn) begin
      mq.delete();
      m_we = 0; m_addr = '0; m_data = '0; m_ret = '0; m_lerr = 0;
      model_on = 1;
    end else if (model_on) begin
      m_push = memValid && (mq.size() < 2);
      m_pop  = (mq.size() > 0) && !stallIn;
      if (m_push) begin
        m_new.rd   = memRdAddr;
        m_new.we   = memRegWrite && (memRdAddr != 5'd0);
        m_new.data = model_data(memWbSel, memLoadType, memAddrLow, memAluResult,
                                memLoadWord, memPcPlus4);
        if (memWbSel == 2'b01 && (memLoadType == 3'b011 || memLoadType == 3'b110 ||
                                  memLoadType == 3'b111))
          m_lerr = 1;
      end
      m_we = 0;
      if (m_pop) begin
        m_head = mq.pop_front();
        m_we   = m_head.we;
        m_addr = m_head.rd;
        m_data = m_head.data;
        m_ret  = m_ret + 32'd1;
      end
      if (m_push) mq.push_back(m_new);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_on) begin
      chk("memReady", {31'd0, memReady}, {31'd0, (!resetIn && mq.size() < 2)});
      chk("writeEnable", {31'd0, writeEnable}, {31'd0, m_we});
      chk("writeAddr", {27'd0, writeAddr}, {27'd0, m_addr});
      chk("writeDate", writeDate, m_data);
      chk("fwdValid", {31'd0, fwdValid}, {31'd0, m_we});
      chk("fwdAddr", {27'd0, fwdAddr}, {27'd0, m_addr});
      chk("fwdData", fwdData, m_data);
      chk("retireCount", retireCount, m_ret);
      chk("loadErr", {31'd0, loadErr}, {31'd0, m_lerr});
      if (writeEnable === 1'b1) wlog.push_back('{addr: writeAddr, data: writeDate});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                       input logic [2:0] lt, input logic [1:0] al, input logic [31:0] alu,
                       input logic [31:0] word, input logic [31:0] pc);
    memRdAddr = rd; memRegWrite = rw; memWbSel = sel; memLoadType = lt;
    memAddrLow = al; memAluResult = alu; memLoadWord = word; memPcPlus4 = pc;
    memValid = 1'b1;
  endtask

  task automatic send(input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                      input logic [2:0] lt, input logic [1:0] al, input logic [31:0] alu,
                      input logic [31:0] word, input logic [31:0] pc);
    bit ok;
    ok = 0;
    drive(rd, rw, sel, lt, al, alu, word, pc);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = memReady;
      @(posedge clk);
      #2;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: rd %0d never accepted", rd);
    end
  endtask

  task automatic idle(input int n);
    memValid = 1'b0;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    memValid = 1'b0;
    stallIn  = 1'b0;
    resetIn  = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    resetIn = 1'b0;
  endtask

  function automatic logic [31:0] log_data(input int idx);
    if (idx < wlog.size()) return wlog[idx].data;
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] log_addr(input int idx);
    if (idx < wlog.size()) return {27'd0, wlog[idx].addr};
    return 32'hFFFF_FFFF;
  endfunction

  localparam logic [31:0] WORD = 32'h80FF7F01;

  int n0;

  initial begin
    do_reset();
    @(negedge clk);
    chk("reset_ready", {31'd0, memReady}, 32'd1);
    chk("reset_retire", retireCount, 32'd0);
    @(posedge clk); #2;

    // ALU op
    n0 = wlog.size();
    send(5'd5, 1'b1, 2'b00, 3'b010, 2'd0, 32'h12345678, 32'd0, 32'd0);
    idle(4);
    chk("alu_count", wlog.size() - n0, 32'd1);
    chk("alu_addr", log_addr(n0), 32'd5);
    chk("alu_data", log_data(n0), 32'h12345678);
    chk("alu_retire", retireCount, 32'd1);

    // loads from 0x80FF7F01, back to back
    n0 = wlog.size();
    send(5'd6,  1'b1, 2'b01, 3'b000, 2'd3, 32'd0, WORD, 32'd0);
    send(5'd7,  1'b1, 2'b01, 3'b100, 2'd3, 32'd0, WORD, 32'd0);
    send(5'd8,  1'b1, 2'b01, 3'b001, 2'd2, 32'd0, WORD, 32'd0);
    send(5'd10, 1'b1, 2'b01, 3'b101, 2'd0, 32'd0, WORD, 32'd0);
    send(5'd11, 1'b1, 2'b01, 3'b010, 2'd1, 32'd0, WORD, 32'd0);
    idle(4);
    chk("lb", log_data(n0), 32'hFFFFFF80);
    chk("lbu", log_data(n0 + 1), 32'h00000080);
    chk("lh", log_data(n0 + 2), 32'hFFFF80FF);
    chk("lhu", log_data(n0 + 3), 32'h00007F01);
    chk("lw", log_data(n0 + 4), 32'h80FF7F01);

    // x0 destination with PC+4 source
    n0 = wlog.size();
    send(5'd0, 1'b1, 2'b10, 3'b000, 2'd0, 32'd0, 32'd0, 32'h00001004);
    idle(4);
    chk("x0_no_write", wlog.size() - n0, 32'd0);
    chk("x0_retire", retireCount, 32'd7);

    // stall: two accepted, third refused until release
    n0 = wlog.size();
    stallIn = 1'b1;
    send(5'd1, 1'b1, 2'b00, 3'b000, 2'd0, 32'h11, 32'd0, 32'd0);
    send(5'd2, 1'b1, 2'b11, 3'b000, 2'd0, 32'h22, 32'd0, 32'd0);
    drive(5'd3, 1'b1, 2'b10, 3'b000, 2'd0, 32'd0, 32'd0, 32'h33);
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready_low", {31'd0, memReady}, 32'd0);
    end
    @(posedge clk); #2;
    stallIn = 1'b0;
    send(5'd3, 1'b1, 2'b10, 3'b000, 2'd0, 32'd0, 32'd0, 32'h33);
    idle(4);
    chk("stall_order0", log_addr(n0), 32'd1);
    chk("stall_order1", log_addr(n0 + 1), 32'd2);
    chk("stall_order2", log_addr(n0 + 2), 32'd3);
    chk("stall_data2", log_data(n0 + 2), 32'h33);

    // unsupported funct3 returns raw word and sets sticky error
    n0 = wlog.size();
    send(5'd9, 1'b1, 2'b01, 3'b011, 2'd2, 32'd0, WORD, 32'd0);
    idle(4);
    chk("err_data", log_data(n0), 32'h80FF7F01);
    chk("err_flag", {31'd0, loadErr}, 32'd1);

    // reset with two entries buffered
    stallIn = 1'b1;
    send(5'd12, 1'b1, 2'b00, 3'b000, 2'd0, 32'hAA, 32'd0, 32'd0);
    send(5'd13, 1'b1, 2'b00, 3'b000, 2'd0, 32'hBB, 32'd0, 32'd0);
    idle(2);
    n0 = wlog.size();
    resetIn = 1'b1;
    stallIn = 1'b0;
    @(posedge clk); #2;
    resetIn = 1'b0;
    idle(5);
    chk("rst_no_writes", wlog.size() - n0, 32'd0);
    chk("rst_retire", retireCount, 32'd0);
    chk("rst_loaderr", {31'd0, loadErr}, 32'd0);

    // continuous stream of 10
    n0 = wlog.size();
    for (int i = 0; i < 10; i++)
      send(5'(i + 1), 1'b1, 2'b00, 3'b000, 2'd0, 32'(i) * 32'h111, 32'd0, 32'd0);
    idle(5);
    chk("stream_retire", retireCount, 32'd10);
    chk("stream_writes", wlog.size() - n0, 32'd10);
    chk("stream_last", log_data(n0 + 9), 32'h999);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
